// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the Hack CPU boot/reload sequencer.
package prog_loader_pkg;

  localparam int SUM_W   = 16;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Boot/reload sequencer: streams words into the instruction ROM, then releases CPU reset.
// Optional checksum verification is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [SUM_W-1:0]  exp_sum,
  input  logic              s_valid,
  input  logic [15:0]       s_data,
  output logic              s_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t state_reg, state_next;

  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   len_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic              rom_we_reg;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [15:0]       rom_wdata_reg;
  logic              done_reg;

  logic accept;
  logic last_beat;
  logic start_ok;
  logic hold_done;

  // s_ready is a pure function of state so the source never sees a loop through s_valid.
  assign s_ready   = (state_reg == ST_LOAD);
  assign accept    = s_ready && s_valid;
  assign last_beat = accept && (count_reg == len_reg - ONE);
  assign start_ok  = start && (state_reg == ST_IDLE || state_reg == ST_RUN || state_reg == ST_ERR);
  assign hold_done = (hold_reg == HOLD_W'(HOLD_CYCLES - 1));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [SUM_W-1:0] sum_reg;
  logic [SUM_W-1:0] exp_sum_reg;
  logic             sum_ok;

  assign sum_ok = (sum_reg == exp_sum_reg);
  assign err    = (state_reg == ST_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg     <= '0;
      exp_sum_reg <= '0;
    end else if (start_ok) begin
      sum_reg     <= '0;
      exp_sum_reg <= exp_sum;
    end else if (accept) begin
      sum_reg <= sum_reg + s_data;
    end
  end
`else
  logic unused_exp_sum;

  assign unused_exp_sum = ^exp_sum;
  assign err            = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start) state_next = (len == '0) ? ST_RELEASE : ST_LOAD;
      end
      ST_LOAD: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (last_beat) state_next = ST_CHECK;
`else
        if (last_beat) state_next = ST_RELEASE;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHECK: state_next = sum_ok ? ST_RELEASE : ST_ERR;
`endif
      ST_RELEASE: begin
        if (hold_done) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      len_reg       <= '0;
      hold_reg      <= '0;
      rom_we_reg    <= 1'b0;
      rom_addr_reg  <= '0;
      rom_wdata_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rom_we_reg <= accept;
      done_reg   <= (state_next == ST_RUN) && (state_reg != ST_RUN);
      hold_reg   <= (state_reg == ST_RELEASE) ? hold_reg + HOLD_W'(1) : '0;
      if (accept) begin
        rom_addr_reg  <= count_reg[ADDR_W-1:0];
        rom_wdata_reg <= s_data;
      end
      // Oversized requests are clamped to the ROM depth so the address never wraps.
      if (start_ok) begin
        len_reg   <= (len > MAX_LEN) ? MAX_LEN : len;
        count_reg <= '0;
      end else if (accept) begin
        count_reg <= count_reg + ONE;
      end
    end
  end

  assign rom_we    = rom_we_reg;
  assign rom_addr  = rom_addr_reg;
  assign rom_wdata = rom_wdata_reg;
  assign done      = done_reg;
  assign cpu_reset = (state_reg != ST_RUN);
  assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_CHECK) || (state_reg == ST_RELEASE);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed sessions plus randomized loads against a session-level model.
module tb_prog_loader;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int HOLD   = 4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   len;
  logic [15:0]       exp_sum;
  logic              s_valid;
  logic [15:0]       s_data;
  logic              s_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  int n_done = 0;

  logic [15:0] rom_cap [DEPTH];
  logic [15:0] wq [$];

  prog_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .exp_sum(exp_sum),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Acts as the instruction ROM and counts write/done events.
  always @(posedge clk) begin
    if (rom_we) begin
      rom_cap[rom_addr] <= rom_wdata;
      n_writes <= n_writes + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] wq_sum(input int n);
    logic [15:0] s = '0;
    for (int i = 0; i < n; i++) s = s + wq[i];
    return s;
  endfunction

  // mode: 0 = valid every cycle, 1 = random valid, 2 = alternating valid.
  task automatic run_session(input int L, input int mode, input logic [15:0] es, input bit poke);
    int eff, idx, guard, pre;
    bit good;
    eff  = (L > DEPTH) ? DEPTH : L;
    good = !CHK_EN || eff == 0 || wq_sum(eff) == es;
    start = 1'b1; len = (ADDR_W+1)'(L); exp_sum = es; s_valid = 1'b0;
    tick();
    start = 1'b0;
    chk("start_cpu_reset", cpu_reset, 1);
    chk("start_busy", busy, 1);
    idx = 0; guard = 0;
    while (idx < eff && guard < 200) begin
      chk("load_s_ready", s_ready, 1);
      case (mode)
        0: s_valid = 1'b1;
        2: s_valid = (guard % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = s_valid ? wq[idx] : 16'($urandom);
      if (poke && idx == 1) begin
        start = 1'b1; len = (ADDR_W+1)'(1);
      end
      tick();
      start = 1'b0;
      if (s_valid) begin
        chk("wr_en", rom_we, 1);
        chk("wr_addr", rom_addr, idx);
        chk("wr_data", rom_wdata, wq[idx]);
        idx++;
      end else begin
        chk("gap_no_wr", rom_we, 0);
      end
      guard++;
    end
    chk("load_count", idx, eff);
    s_valid = 1'b1; s_data = 16'hDEAD;
    chk("post_s_ready", s_ready, 0);
    chk("post_cpu_reset", cpu_reset, 1);
    pre = HOLD + ((CHK_EN && eff > 0) ? 1 : 0);
    if (!good) begin
      tick();
      chk("err_flag", err, 1);
      chk("err_cpu_reset", cpu_reset, 1);
      chk("err_busy", busy, 0);
      chk("err_no_wr", rom_we, 0);
      repeat (3) begin
        tick();
        chk("err_stay", err, 1);
        chk("err_stay_cpu_reset", cpu_reset, 1);
        chk("err_no_done", done, 0);
      end
    end else begin
      for (int k = 1; k < pre; k++) begin
        tick();
        chk("hold_cpu_reset", cpu_reset, 1);
        chk("hold_no_done", done, 0);
        chk("hold_no_wr", rom_we, 0);
      end
      tick();
      chk("run_cpu_reset", cpu_reset, 0);
      chk("run_done", done, 1);
      chk("run_busy", busy, 0);
      chk("run_err", err, 0);
      tick();
      chk("done_pulse_end", done, 0);
      chk("run_stay", cpu_reset, 0);
      chk("run_no_wr", rom_we, 0);
    end
    s_valid = 1'b0;
    for (int i = 0; i < eff; i++) chk("rom_content", rom_cap[i], wq[i]);
    $display("session len=%0d eff=%0d mode=%0d good=%0d writes=%0d", L, eff, mode, good, n_writes);
  endtask

  initial begin
    int wr_base, done_base, L;
    logic [15:0] es;
    reset = 1'b1; start = 1'b0; len = '0; exp_sum = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) tick();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_rom_we", rom_we, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_wdata", rom_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    // start asserted together with reset must be ignored
    start = 1'b1; len = (ADDR_W+1)'(2);
    tick();
    start = 1'b0; reset = 1'b0;
    chk("rst_wins_busy", busy, 0);
    tick();
    chk("idle_busy", busy, 0);

    wq = '{16'h0010, 16'hE308, 16'hEA87};
    run_session(3, 0, wq_sum(3), 1'b0);
    wq = '{16'h1111, 16'h2222};
    run_session(2, 2, wq_sum(2), 1'b0);
    run_session(0, 0, 16'h0000, 1'b0);

    wq = '{16'h1234, 16'h0001};
    run_session(2, 0, 16'h1235, 1'b0);
    run_session(2, 0, 16'h1236, 1'b0);
    run_session(2, 1, 16'h1235, 1'b0);

    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(16'($urandom));
    run_session(5, 0, wq_sum(5), 1'b1);

    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(16'($urandom));
    run_session(DEPTH + 4, 1, wq_sum(DEPTH), 1'b0);

    for (int r = 0; r < 6; r++) begin
      L = $urandom_range(1, 10);
      wq.delete();
      for (int i = 0; i < L; i++) wq.push_back(16'($urandom));
      es = wq_sum(L) ^ 16'($urandom_range(0, 1));
      run_session(L, 1, es, 1'b0);
    end

    // reset partway through a 3-word load
    wq = '{16'h00A5, 16'h0B0B, 16'h0C0C};
    start = 1'b1; len = (ADDR_W+1)'(3);
    tick();
    start = 1'b0;
    wr_base = n_writes; done_base = n_done;
    s_valid = 1'b1; s_data = wq[0];
    tick();
    s_valid = 1'b0;
    chk("mid_wr_en", rom_we, 1);
    chk("mid_wr_addr", rom_addr, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_cpu_reset", cpu_reset, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_rom_we", rom_we, 0);
    s_valid = 1'b1; s_data = 16'hBEEF;
    repeat (8) tick();
    s_valid = 1'b0;
    chk("mid_rst_writes", n_writes, wr_base + 1);
    chk("mid_rst_no_done", n_done, done_base);
    chk("mid_rst_rom_kept", rom_cap[0], wq[0]);
    $display("reset mid-session writes=%0d done=%0d", n_writes - wr_base, n_done - done_base);

    wq = '{16'h7777};
    run_session(1, 0, wq_sum(1), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
